// File: rtl/id_ex_reg_pkg.sv
// id_ex_reg_pkg: shared MIPS pipeline widths, ALU op codes and control-field types
package id_ex_reg_pkg;
  localparam int DEF_NBITS = 32;
  localparam int DEF_RBITS = 5;
  localparam int SHBITS = 5;
  localparam int DEF_ALUOPBITS = 4;
  localparam int DEF_CNTBITS = 16;
  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_NOR = 4'h5,
    ALU_SLT = 4'h6,
    ALU_SLL = 4'h7,
    ALU_SRL = 4'h8,
    ALU_SRA = 4'h9,
    ALU_LUI = 4'hA
  } alu_op_e;
  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } side_effect_ctrl_t;
  localparam int GATEDBITS = $bits(side_effect_ctrl_t);
endpackage

// File: rtl/id_ex_reg_pipe_field_reg.sv
// pipe_field_reg: W-bit pipeline field register with async reset, sync clear and enable
module pipe_field_reg #(
  parameter int W = 1,
  parameter logic [W-1:0] RSTVAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // clear beats enable so a bubble wins over a hold; d is ignored unless loading
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= RSTVAL;
    else if (clr) q <= RSTVAL;
    else if (en) q <= d;
endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with stall, flush, valid and bubble counting
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int NBITS = DEF_NBITS,
  parameter int RBITS = DEF_RBITS,
  parameter int ALUOPBITS = DEF_ALUOPBITS,
  parameter int CNTBITS = DEF_CNTBITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  logic [NBITS-1:0]     i_pc4,
  input  logic [NBITS-1:0]     i_rs_data,
  input  logic [NBITS-1:0]     i_rt_data,
  input  logic [NBITS-1:0]     i_ext_imm,
  input  logic [RBITS-1:0]     i_rs_addr,
  input  logic [RBITS-1:0]     i_rt_addr,
  input  logic [RBITS-1:0]     i_rd_addr,
  input  logic [SHBITS-1:0]    i_shamt,
  input  logic [ALUOPBITS-1:0] i_alu_op,
  input  logic                 i_alu_src,
  input  logic                 i_reg_dst,
  input  logic                 i_branch,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic                 i_mem_to_reg,
  input  logic                 i_reg_write,
  output logic [NBITS-1:0]     o_pc4,
  output logic [NBITS-1:0]     o_rs_data,
  output logic [NBITS-1:0]     o_rt_data,
  output logic [NBITS-1:0]     o_ext_imm,
  output logic [RBITS-1:0]     o_rs_addr,
  output logic [RBITS-1:0]     o_rt_addr,
  output logic [RBITS-1:0]     o_rd_addr,
  output logic [SHBITS-1:0]    o_shamt,
  output logic [ALUOPBITS-1:0] o_alu_op,
  output logic                 o_alu_src,
  output logic                 o_reg_dst,
  output logic                 o_branch,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic                 o_mem_to_reg,
  output logic                 o_reg_write,
  output logic                 o_valid,
  output logic [CNTBITS-1:0]   o_bubble_cnt
);
  logic load;
  logic bubble;
  side_effect_ctrl_t gated;
  assign load = !i_stall;
  assign bubble = i_flush || (load && !i_valid);
  assign gated = i_valid ? {i_branch, i_mem_read, i_mem_write, i_mem_to_reg, i_reg_write} : '0;
  pipe_field_reg #(.W(4*NBITS)) u_data (
    .clk(i_clk),
    .rst(i_rst),
    .clr(i_flush),
    .en (load),
    .d  ({i_pc4, i_rs_data, i_rt_data, i_ext_imm}),
    .q  ({o_pc4, o_rs_data, o_rt_data, o_ext_imm})
  );
  pipe_field_reg #(.W(3*RBITS+SHBITS)) u_addr (
    .clk(i_clk),
    .rst(i_rst),
    .clr(i_flush),
    .en (load),
    .d  ({i_rs_addr, i_rt_addr, i_rd_addr, i_shamt}),
    .q  ({o_rs_addr, o_rt_addr, o_rd_addr, o_shamt})
  );
  pipe_field_reg #(.W(ALUOPBITS+2+GATEDBITS)) u_ctrl (
    .clk(i_clk),
    .rst(i_rst),
    .clr(i_flush),
    .en (load),
    .d  ({i_alu_op, i_alu_src, i_reg_dst, gated}),
    .q  ({o_alu_op, o_alu_src, o_reg_dst, o_branch, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write})
  );
  // valid follows the loaded instruction; bubble counter saturates at all-ones
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      o_valid <= 1'b0;
      o_bubble_cnt <= '0;
    end else begin
      o_valid <= i_flush ? 1'b0 : load ? i_valid : o_valid;
      if (bubble && !(&o_bubble_cnt)) o_bubble_cnt <= o_bubble_cnt + 1'b1;
    end
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: randomized and directed check of id_ex_reg against a behavioural model
module tb_id_ex_reg;
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] ext_imm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [4:0]  shamt;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        reg_dst;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
  } bundle_t;

  logic clk = 0;
  logic rst = 1;
  logic stall = 0;
  logic flush = 0;
  logic valid = 0;
  bundle_t in;
  bundle_t act;
  bundle_t exp_b;
  logic exp_valid;
  int exp_cnt;
  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  logic [31:0] o_pc4, o_rs_data, o_rt_data, o_ext_imm;
  logic [4:0] o_rs_addr, o_rt_addr, o_rd_addr, o_shamt;
  logic [3:0] o_alu_op;
  logic o_alu_src, o_reg_dst, o_branch, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write;
  logic o_valid;
  logic [15:0] o_cnt;

  assign act = {o_pc4, o_rs_data, o_rt_data, o_ext_imm, o_rs_addr, o_rt_addr, o_rd_addr, o_shamt,
                o_alu_op, o_alu_src, o_reg_dst, o_branch, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write};

  id_ex_reg dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush), .i_valid(valid),
    .i_pc4(in.pc4), .i_rs_data(in.rs_data), .i_rt_data(in.rt_data), .i_ext_imm(in.ext_imm),
    .i_rs_addr(in.rs_addr), .i_rt_addr(in.rt_addr), .i_rd_addr(in.rd_addr), .i_shamt(in.shamt),
    .i_alu_op(in.alu_op), .i_alu_src(in.alu_src), .i_reg_dst(in.reg_dst), .i_branch(in.branch),
    .i_mem_read(in.mem_read), .i_mem_write(in.mem_write), .i_mem_to_reg(in.mem_to_reg),
    .i_reg_write(in.reg_write),
    .o_pc4(o_pc4), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_ext_imm(o_ext_imm),
    .o_rs_addr(o_rs_addr), .o_rt_addr(o_rt_addr), .o_rd_addr(o_rd_addr), .o_shamt(o_shamt),
    .o_alu_op(o_alu_op), .o_alu_src(o_alu_src), .o_reg_dst(o_reg_dst), .o_branch(o_branch),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg),
    .o_reg_write(o_reg_write), .o_valid(o_valid), .o_bubble_cnt(o_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] a, input logic [159:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic model_reset();
    exp_b = '0;
    exp_valid = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic count_bubble();
    exp_cnt = (exp_cnt >= 65535) ? 65535 : exp_cnt + 1;
  endtask

  // what EX must hold after an edge with the currently driven inputs
  task automatic model_edge();
    if (rst) model_reset();
    else if (flush) begin
      exp_b = '0;
      exp_valid = 1'b0;
      count_bubble();
    end else if (!stall) begin
      exp_b = in;
      exp_valid = valid;
      if (!valid) begin
        exp_b.branch = 1'b0;
        exp_b.mem_read = 1'b0;
        exp_b.mem_write = 1'b0;
        exp_b.mem_to_reg = 1'b0;
        exp_b.reg_write = 1'b0;
        count_bubble();
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic rand_in();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    in = r[158:0];
  endtask

  always @(negedge clk)
    if (chk_en) begin
      chk("bundle", act, exp_b);
      chk("valid", o_valid, exp_valid);
      chk("bubble_cnt", o_cnt, exp_cnt[15:0]);
    end

  initial begin
    in = '0;
    model_reset();
    chk_en = 1;
    repeat (2) cyc();
    chk("rst_valid", o_valid, 0);
    chk("rst_cnt", o_cnt, 0);
    rst = 0;
    rand_in();
    in.ext_imm = 32'hFFFFF00F;
    in.rs_data = 32'h12345678;
    in.reg_write = 1'b1;
    valid = 1;
    cyc();
    chk("load_imm", o_ext_imm, 32'hFFFFF00F);
    chk("load_rs", o_rs_data, 32'h12345678);
    chk("load_regwr", o_reg_write, 1);
    chk("load_valid", o_valid, 1);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) in = 'x;
      else rand_in();
      valid = i[0];
      cyc();
      chk("stall_imm", o_ext_imm, 32'hFFFFF00F);
      chk("stall_rs", o_rs_data, 32'h12345678);
      chk("stall_valid", o_valid, 1);
      chk("stall_cnt", o_cnt, 0);
    end
    rand_in();
    flush = 1;
    cyc();
    chk("flush_bundle", act, 0);
    chk("flush_valid", o_valid, 0);
    chk("flush_cnt", o_cnt, 1);
    flush = 0;
    stall = 0;
    rand_in();
    valid = 0;
    in.mem_write = 1'b1;
    in.ext_imm = 32'h0000000F;
    cyc();
    chk("inv_memwr", o_mem_write, 0);
    chk("inv_imm", o_ext_imm, 32'h0000000F);
    chk("inv_valid", o_valid, 0);
    chk("inv_cnt", o_cnt, 2);
    repeat (3000) begin
      rand_in();
      stall = ($urandom_range(3) == 0);
      flush = ($urandom_range(7) == 0);
      valid = ($urandom_range(3) != 0);
      cyc();
    end
    stall = 0;
    flush = 0;
    valid = 1;
    rand_in();
    in.pc4[0] = 1'b1;
    cyc();
    chk("pre_rst_valid", o_valid, 1);
    #2 rst = 1;
    model_reset();
    #1;
    chk("async_rst_bundle", act, 0);
    chk("async_rst_valid", o_valid, 0);
    chk("async_rst_cnt", o_cnt, 0);
    @(negedge clk);
    rst = 0;
    flush = 1;
    repeat (65537) cyc();
    chk("sat_cnt", o_cnt, 16'hFFFF);
    cyc();
    chk("sat_hold", o_cnt, 16'hFFFF);
    flush = 0;
    valid = 0;
    cyc();
    chk("sat_inv_hold", o_cnt, 16'hFFFF);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
